// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency RAM read port between NREQ requesters.
// Define ARB_STATS_EN to add a saturating 16-bit grant counter output (grant_cnt).
module ram_port_arbiter #(
  parameter int unsigned NREQ    = 6,
  parameter int unsigned AW      = 8,
  parameter int unsigned DW      = 32,
  parameter int unsigned RAM_LAT = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*AW-1:0]         req_addr,
  output logic [NREQ-1:0]            gnt,
  output logic                       ram_en,
  output logic [AW-1:0]              ram_addr,
  input  logic [DW-1:0]              ram_rdata,
  output logic                       rsp_valid,
  output logic [$clog2(NREQ)-1:0]    rsp_id,
  output logic [DW-1:0]              rsp_data
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]                grant_cnt
`endif
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned CW = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e          state_q;
  logic [IW-1:0]   ptr_q;
  logic [IW-1:0]   sel_id_q;
  logic [CW-1:0]   wait_cnt_q;
  logic [IW-1:0]   ptr_next;

  logic [AW-1:0]   addr_arr [NREQ];
  logic            arb_valid;
  logic [IW-1:0]   arb_id;
  logic [AW-1:0]   arb_addr;
  logic [NREQ-1:0] arb_onehot;
  logic [31:0]     idx_full;
  logic [IW-1:0]   idx;

  for (genvar i = 0; i < NREQ; i++) begin : g_addr
    assign addr_arr[i] = req_addr[i*AW +: AW];
  end

  // First set request at or after ptr_q, wrapping NREQ-1 -> 0.
  always_comb begin
    arb_valid  = 1'b0;
    arb_id     = '0;
    arb_addr   = '0;
    arb_onehot = '0;
    idx_full   = '0;
    idx        = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx_full = ({{(32-IW){1'b0}}, ptr_q} + k) % NREQ;
      idx      = idx_full[IW-1:0];
      if (!arb_valid && req[idx]) begin
        arb_valid       = 1'b1;
        arb_id          = idx;
        arb_addr        = addr_arr[idx];
        arb_onehot[idx] = 1'b1;
      end
    end
  end

  assign ptr_next = (sel_id_q == IW'(NREQ - 1)) ? '0 : sel_id_q + IW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      sel_id_q   <= '0;
      wait_cnt_q <= '0;
      gnt        <= '0;
      ram_en     <= 1'b0;
      ram_addr   <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_data   <= '0;
    end else begin
      gnt       <= '0;
      ram_en    <= 1'b0;
      rsp_valid <= 1'b0;
      unique case (state_q)
        StIdle, StResp: begin
          if (arb_valid) begin
            sel_id_q <= arb_id;
            ram_addr <= arb_addr;
            gnt      <= arb_onehot;
            ram_en   <= 1'b1;
            state_q  <= StIssue;
          end else begin
            state_q <= StIdle;
          end
        end
        StIssue: begin
          ptr_q      <= ptr_next;
          wait_cnt_q <= CW'(RAM_LAT - 1);
          state_q    <= StWait;
        end
        StWait: begin
          // Counter reaches zero on the cycle the RAM word is valid.
          if (wait_cnt_q == '0) begin
            rsp_data  <= ram_rdata;
            rsp_id    <= sel_id_q;
            rsp_valid <= 1'b1;
            state_q   <= StResp;
          end else begin
            wait_cnt_q <= wait_cnt_q - CW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt <= '0;
    end else if (state_q == StIssue && grant_cnt != 16'hFFFF) begin
      grant_cnt <= grant_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a latency-accurate RAM model and grant/response
// scoreboard queues. Covers ARB_STATS_EN when the macro is defined.
module tb_ram_port_arbiter;

  localparam int NREQ = 6;
  localparam int AW   = 8;
  localparam int DW   = 32;
  localparam int LAT  = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NREQ-1:0]   req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ-1:0]   gnt;
  logic              ram_en;
  logic [AW-1:0]     ram_addr;
  logic [DW-1:0]     ram_rdata;
  logic              rsp_valid;
  logic [2:0]        rsp_id;
  logic [DW-1:0]     rsp_data;
`ifdef ARB_STATS_EN
  logic [15:0]       grant_cnt;
`endif

  always #5 clk = ~clk;

  ram_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .RAM_LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_addr  (req_addr),
    .gnt       (gnt),
    .ram_en    (ram_en),
    .ram_addr  (ram_addr),
    .ram_rdata (ram_rdata),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data)
`ifdef ARB_STATS_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a);
    return {16'hDEAD, 8'h00, a};
  endfunction

  // RAM model: word for the strobed address is valid exactly LAT cycles after ram_en.
  logic [LAT-1:0] en_pipe;
  logic [AW-1:0]  a_pipe [LAT];
  always @(posedge clk) begin
    en_pipe[0] <= ram_en;
    a_pipe[0]  <= ram_addr;
    for (int i = 1; i < LAT; i++) begin
      en_pipe[i] <= en_pipe[i-1];
      a_pipe[i]  <= a_pipe[i-1];
    end
  end
  assign ram_rdata = en_pipe[LAT-1] ? ram_word(a_pipe[LAT-1]) : 32'hBAD0BAD0;

  typedef struct {int id; logic [AW-1:0] addr;} gexp_t;
  typedef struct {int id; logic [DW-1:0] data;} rexp_t;

  gexp_t          gq[$];
  rexp_t          rq[$];
  logic [AW-1:0]  addr_of [NREQ];
  int             checks = 0;
  int             errors = 0;
  int             cyc = 0;
  bit             seen_gnt;
  bit             seen_rsp;
  int             seen_id;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    addr_of[i] = a;
    req_addr[i*AW +: AW] = a;
  endtask

  task automatic expect_gnt(input int id);
    gq.push_back('{id: id, addr: addr_of[id]});
  endtask

  task automatic expect_req(input int id);
    expect_gnt(id);
    rq.push_back('{id: id, data: ram_word(addr_of[id])});
  endtask

  // Advance to the next falling edge and score any grant or response seen there.
  task automatic tick();
    gexp_t ge;
    rexp_t re;
    @(negedge clk);
    cyc++;
    seen_gnt = 1'b0;
    seen_rsp = 1'b0;
    seen_id  = -1;
    if (!rst) begin
      if (gnt !== '0 || ram_en !== 1'b0) begin
        seen_gnt = 1'b1;
        if (gq.size() == 0) begin
          chk("unexpected_gnt", {ram_en, gnt}, 0);
        end else begin
          ge = gq.pop_front();
          chk("gnt", gnt, 64'(1) << ge.id);
          chk("ram_en", ram_en, 1);
          chk("ram_addr", ram_addr, ge.addr);
          seen_id = ge.id;
        end
      end
      if (rsp_valid !== 1'b0) begin
        seen_rsp = 1'b1;
        if (rq.size() == 0) begin
          chk("unexpected_rsp", rsp_valid, 0);
        end else begin
          re = rq.pop_front();
          chk("rsp_id", rsp_id, re.id);
          chk("rsp_data", rsp_data, re.data);
        end
      end
    end
  endtask

  task automatic wait_gnt(output int id);
    bit got;
    got = 1'b0;
    id  = -1;
    for (int n = 0; n < 20 && !got; n++) begin
      tick();
      if (seen_gnt) begin
        got = 1'b1;
        id  = seen_id;
      end
    end
    if (!got) chk("gnt_timeout", got, 1);
  endtask

  task automatic drain();
    for (int n = 0; n < 40 && (gq.size() + rq.size()) != 0; n++) tick();
    chk("queues_empty", gq.size() + rq.size(), 0);
    repeat (3) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic serve(input int id);
    int g;
    wait_gnt(g);
    if (g >= 0) req[g] = 1'b0;
    chk("served_id", g, id);
  endtask

  initial begin
    int id;
    int last;
    req      = '0;
    req_addr = '0;
    for (int i = 0; i < NREQ; i++) set_addr(i, 8'h30 + 8'(i));

    // Reset state
    #2 rst = 1'b1;
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_ram_en", ram_en, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_data", rsp_data, 0);
`ifdef ARB_STATS_EN
    chk("rst_grant_cnt", grant_cnt, 0);
`endif
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Single request: grant at T+1, response at T+4
    set_addr(2, 8'h15);
    req[2] = 1'b1;
    expect_req(2);
    tick();
    chk("t1_gnt_at_T1", seen_gnt, 1);
    req[2] = 1'b0;
    tick();
    chk("t1_no_rsp_T2", rsp_valid, 0);
    tick();
    chk("t1_no_rsp_T3", rsp_valid, 0);
    tick();
    chk("t1_rsp_at_T4", seen_rsp, 1);
    repeat (6) tick();
    chk("t1_rsp_data_held", rsp_data, 32'hDEAD0015);
    chk("t1_rsp_id_held", rsp_id, 2);
    drain();

    // All six continuously requesting from ptr=0
    do_reset();
    for (int k = 0; k < 7; k++) expect_req(k % NREQ);
    req  = '1;
    last = 0;
    for (int k = 0; k < 7; k++) begin
      wait_gnt(id);
      chk("rr_order", id, k % NREQ);
      if (k > 0) chk("rr_spacing", cyc - last, 4);
      last = cyc;
      if (k == 6) begin
        req = '0;
      end else if (id >= 0) begin
        req[id] = 1'b0;
        tick();
        req[id] = 1'b1;
      end
    end
    drain();

    // Pointer skip: after grant 3, {1,5} -> 5 then 1
    req[3] = 1'b1;
    expect_req(3);
    serve(3);
    drain();
    expect_req(5);
    expect_req(1);
    req[1] = 1'b1;
    req[5] = 1'b1;
    serve(5);
    serve(1);
    drain();

    // Wrap: after grant 5, {0,5} -> 0 then 5
    req[5] = 1'b1;
    expect_req(5);
    serve(5);
    drain();
    expect_req(0);
    expect_req(5);
    req[0] = 1'b1;
    req[5] = 1'b1;
    serve(0);
    serve(5);
    drain();

    // Reset during the first WAIT cycle abandons the transaction
    req[3] = 1'b1;
    expect_gnt(3);
    serve(3);
    tick();
    rst = 1'b1;
    #1;
    chk("midrst_gnt", gnt, 0);
    chk("midrst_ram_en", ram_en, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_rsp_data", rsp_data, 0);
    tick();
    tick();
    rst = 1'b0;
    repeat (8) tick();
    expect_req(0);
    expect_req(4);
    req[0] = 1'b1;
    req[4] = 1'b1;
    serve(0);
    serve(4);
    drain();

`ifdef ARB_STATS_EN
    req[2] = 1'b1;
    expect_req(2);
    serve(2);
    drain();
    chk("stats_cnt_3", grant_cnt, 3);
    force dut.grant_cnt = 16'hFFFE;
    #1;
    release dut.grant_cnt;
    for (int k = 0; k < 3; k++) begin
      req[2] = 1'b1;
      expect_req(2);
      serve(2);
      drain();
    end
    chk("stats_cnt_sat", grant_cnt, 16'hFFFF);
    rst = 1'b1;
    #1;
    chk("stats_cnt_rst", grant_cnt, 0);
    tick();
    rst = 1'b0;
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
Round-robin arbiter that shares one ram32 read port between the core requesters of the sexy_grid fabric (six cores by default).
- Accepts per-core request/address pairs and grants one requester at a time.
- Issues a single fixed-latency read to the RAM controller.
- Routes the returned word back tagged with the requester ID.
- Sits between gen_cores and gen_ram, replacing the direct core-to-RAM wiring.

Parameters:
NREQ, 6, number of requesters (2..8)
AW, 8, address width per requester
DW, 32, data width
RAM_LAT, 2, RAM read latency in cycles from ram_en to valid ram_rdata (>=1; 0 illegal)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
req  in  NREQ  per-requester request level
req_addr  in  NREQ*AW  packed addresses; requester i occupies bits [i*AW +: AW]
gnt  out  NREQ  one-hot grant pulse, one cycle
ram_en  out  1  read strobe to RAM controller, one cycle
ram_addr  out  AW  read address, valid while ram_en=1
ram_rdata  in  DW  RAM read data
rsp_valid  out  1  response strobe, one cycle
rsp_id  out  3  index of the served requester (width $clog2(NREQ), 3 at default)
rsp_data  out  DW  response word, held until the next response

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- While rst=1, all registers clear immediately:
  - state=IDLE, ptr=0
  - gnt=0, ram_en=0, ram_addr=0, rsp_valid=0, rsp_id=0, rsp_data=0
- Any in-flight transaction is abandoned; ram_rdata arriving after reset release is ignored.
- State machine:
  - IDLE: if any req bit is set, select the first set bit searching ptr, ptr+1, ... wrapping NREQ-1 -> 0. Latch sel_id and req_addr[sel]; go to ISSUE. Otherwise stay in IDLE.
  - ISSUE (1 cycle): gnt[sel_id]=1, ram_en=1, ram_addr=latched address. Set ptr = sel_id+1, with NREQ-1 wrapping to 0. Go to WAIT.
  - WAIT (RAM_LAT cycles, down-counter): on the edge ending the last WAIT cycle, capture ram_rdata into rsp_data and sel_id into rsp_id. Go to RESP.
  - RESP (1 cycle): rsp_valid=1. Arbitrates exactly as IDLE: any req goes to ISSUE next, else go to IDLE.
- Timing: request seen in cycle T gives:
  - gnt and ram_en at T+1
  - data sampled at the end of T+1+RAM_LAT
  - rsp_valid at T+2+RAM_LAT
- Throughput under continuous requests: one grant per RAM_LAT+2 cycles.
- Requester rules:
  - A requester holds req until it sees its gnt, then drops req by the following cycle.
  - req still high in the RESP or IDLE evaluation cycle is treated as a new request.
  - req dropped before grant is not served; no error is raised.
- req changes during ISSUE and WAIT are ignored; only the IDLE and RESP evaluations matter.
- gnt is always zero-hot or one-hot; ram_en and the gnt pulse are coincident.
- rsp_data and rsp_id are stable outside RESP and keep the last response.

Optional Feature:
Macro ARB_STATS_EN.
- Defined: adds output port grant_cnt [15:0].
  - Increments once per ISSUE cycle.
  - Saturates at 0xFFFF.
  - Clears to 0 on rst.
- Undefined: grant_cnt port and counter are absent; all other behaviour is identical.

Test Plan:
- Single request: req[2]=1, addr 0x15 at cycle T, RAM model returns 0xDEAD0015. Required: gnt=6'b000100 and ram_en=1, ram_addr=0x15 at T+1; rsp_valid at T+4 with rsp_id=2, rsp_data=0xDEAD0015. No further gnt once req drops.
- All six requesting continuously (each re-raising after its grant): grants in order 0,1,2,3,4,5,0 at 4-cycle spacing; each rsp_id matches the grant order.
- Pointer skip: after a grant to 3, assert req[1] and req[5] together -> grant 5 first, then 1.
- Wrap: after a grant to 5, assert req[0] and req[5] -> grant 0 first, then 5.
- Reset mid-WAIT: assert rst during the first WAIT cycle.
  - gnt, ram_en and rsp_valid are 0 immediately; ptr resets to 0; no rsp_valid follows.
  - After release, req[4] and req[0] together -> grant 0.
- With ARB_STATS_EN: 3 grants -> grant_cnt=3; preload the counter to 0xFFFE via force, 3 more grants -> grant_cnt=0xFFFF; rst -> 0.
